// File: rtl/bus_arb_enum.sv
// Shared types for the core memory-port arbiter: FSM states, the transaction
// owner, and the all-lanes byte-enable constant.
package bus_arb_enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

  // Wide enough for XLEN up to 64; callers slice the lanes they need.
  localparam int                  BE_MAX_W = 8;
  localparam logic [BE_MAX_W-1:0] BE_ALL   = '1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the requester (IFU/LSU) and memory-side signals of the arbiter.
// slave = arbiter view, master = surrounding fetch/LSU/memory view.
interface bus_arbiter_if #(
  parameter int XLEN = 32
);

  // Handshake: a requester holds req and its attributes until gnt pulses;
  // each gnt is followed by exactly one rvalid pulse (loads and stores).
  // Memory sees the same req/gnt/rvalid contract, one outstanding at a time.
  logic            ifu_req_i;
  logic [XLEN-1:0] ifu_addr_i;
  logic            ifu_gnt_o;
  logic            ifu_rvalid_o;
  logic [XLEN-1:0] ifu_rdata_o;

  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [XLEN/8-1:0] lsu_be_i;
  logic [XLEN-1:0]   lsu_addr_i;
  logic [XLEN-1:0]   lsu_wdata_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic [XLEN-1:0]   lsu_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  logic              err_o;

  modport slave (
    input  ifu_req_i, ifu_addr_i,
    input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output err_o
  );

  modport master (
    output ifu_req_i, ifu_addr_i,
    output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  err_o
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter: counts lost arbitrations of a waiting
// requester and flags when it has waited MAX times in a row.
module arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign at_max = (cnt == W'(MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter sharing the single core memory port between IFU and LSU, one
// outstanding transaction. Optional response timeout: BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_enum::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bus_arbiter_if.slave  bus,
  output state_t        state_o
);

  localparam int BW = XLEN / 8;

  state_t          state, state_nxt;
  owner_t          owner;
  logic            load, pick_ifu, gnt_fire, rsp_fire, rv_fire;
  logic            tmo_hit, starve_at_max, starve_inc, starve_clr;
  logic            we_q;
  logic [BW-1:0]   be_q;
  logic [XLEN-1:0] addr_q, wdata_q;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pick_ifu  = 1'b0;
    gnt_fire  = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ifu_req_i || bus.lsu_req_i) begin
          load      = 1'b1;
          pick_ifu  = bus.ifu_req_i && (!bus.lsu_req_i || starve_at_max);
          state_nxt = REQ;
        end
      end
      REQ: begin
        // gnt wins over a same-cycle rvalid: only one transaction is in flight
        if (bus.mem_gnt_i) begin
          gnt_fire  = 1'b1;
          state_nxt = RSP;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      RSP: begin
        if (bus.mem_rvalid_i) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner   <= OWNER_LSU;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        owner   <= pick_ifu ? OWNER_IFU : OWNER_LSU;
        we_q    <= pick_ifu ? 1'b0 : bus.lsu_we_i;
        be_q    <= pick_ifu ? BE_ALL[BW-1:0] : bus.lsu_be_i;
        addr_q  <= pick_ifu ? bus.ifu_addr_i : bus.lsu_addr_i;
        wdata_q <= pick_ifu ? '0 : bus.lsu_wdata_i;
      end
    end
  end

  // Only an LSU win over a waiting IFU counts as starvation.
  assign starve_inc = load && !pick_ifu && bus.ifu_req_i;
  assign starve_clr = load && !starve_inc;

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE || state_nxt != state) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT)) &&
                   !(state == REQ && bus.mem_gnt_i) &&
                   !(state == RSP && bus.mem_rvalid_i);
`else
  wire unused_timeout = (TIMEOUT > 0);
  assign tmo_hit = 1'b0;
`endif

  // A timeout completes the owner's transaction with zero data.
  assign rv_fire = rsp_fire || tmo_hit;

  assign bus.ifu_gnt_o    = gnt_fire && (owner == OWNER_IFU);
  assign bus.lsu_gnt_o    = gnt_fire && (owner == OWNER_LSU);
  assign bus.ifu_rvalid_o = rv_fire && (owner == OWNER_IFU);
  assign bus.lsu_rvalid_o = rv_fire && (owner == OWNER_LSU);
  assign bus.ifu_rdata_o  = (rsp_fire && owner == OWNER_IFU) ? bus.mem_rdata_i : '0;
  assign bus.lsu_rdata_o  = (rsp_fire && owner == OWNER_LSU) ? bus.mem_rdata_i : '0;

  assign bus.mem_req_o   = (state == REQ);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_be_o    = be_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.err_o       = tmo_hit;

  assign state_o = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (STARVE_MAX=4, TIMEOUT=8).
// Timeout scenario runs when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;
  import bus_arb_enum::*;

  logic   clk;
  logic   rst;
  state_t state;
  int     checks;
  int     errors;
  int     viol_cnt;

  bus_arbiter_if #(.XLEN(32)) bus ();

  bus_arbiter #(
    .XLEN       (32),
    .STARVE_MAX (4),
    .TIMEOUT    (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory-side protocol monitor: gnt and rvalid together while in REQ.
  always @(posedge clk) begin
    if (!rst && state == REQ && bus.mem_gnt_i && bus.mem_rvalid_i) begin
      viol_cnt <= viol_cnt + 1;
      $display("note: memory returned gnt and rvalid in the same REQ cycle");
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ifu_req_i    = 1'b0;
    bus.ifu_addr_i   = '0;
    bus.lsu_req_i    = 1'b0;
    bus.lsu_we_i     = 1'b0;
    bus.lsu_be_i     = '0;
    bus.lsu_addr_i   = '0;
    bus.lsu_wdata_i  = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  // Plays memory for one transaction; called post-edge with DUT in IDLE.
  task automatic run_txn(input int gnt_wait, input logic [31:0] rdata,
                         input logic drop_ifu, input logic drop_lsu,
                         output logic ok, output logic [1:0] gnt_seen,
                         output logic [1:0] rv_seen,
                         output logic [31:0] ifu_rd, output logic [31:0] lsu_rd,
                         output logic we_seen, output logic [3:0] be_seen,
                         output logic [31:0] addr_seen, output logic [31:0] wdata_seen);
    int n;
    ok = 1'b0; gnt_seen = '0; rv_seen = '0; ifu_rd = '0; lsu_rd = '0;
    we_seen = 1'b0; be_seen = '0; addr_seen = '0; wdata_seen = '0;
    n = 0;
    while (n < 8 && !ok) begin
      tick();
      n++;
      ok = (bus.mem_req_o === 1'b1);
    end
    if (!ok) return;
    we_seen = bus.mem_we_o; be_seen = bus.mem_be_o;
    addr_seen = bus.mem_addr_o; wdata_seen = bus.mem_wdata_o;
    repeat (gnt_wait) tick();
    bus.mem_gnt_i = 1'b1;
    #1;
    gnt_seen = {bus.ifu_gnt_o, bus.lsu_gnt_o};
    if (drop_ifu && bus.ifu_gnt_o) bus.ifu_req_i = 1'b0;
    if (drop_lsu && bus.lsu_gnt_o) bus.lsu_req_i = 1'b0;
    tick();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rdata;
    #1;
    rv_seen = {bus.ifu_rvalid_o, bus.lsu_rvalid_o};
    ifu_rd  = bus.ifu_rdata_o;
    lsu_rd  = bus.lsu_rdata_o;
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE);
    end
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin
      errors++; $display("FAIL reset_mem: got req=%b we=%b be=%h addr=%h wdata=%h expected all 0",
                         bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    checks++;
    if ({bus.ifu_gnt_o, bus.ifu_rvalid_o, bus.lsu_gnt_o, bus.lsu_rvalid_o, bus.err_o} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000",
                         {bus.ifu_gnt_o, bus.ifu_rvalid_o, bus.lsu_gnt_o, bus.lsu_rvalid_o, bus.err_o});
    end
  endtask

  task automatic test_ifu_fetch();
    bus.ifu_req_i  = 1'b1;
    bus.ifu_addr_i = 32'h0000_0100;
    tick();
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      errors++; $display("FAIL ifu_req_attr: got req=%b we=%b be=%h addr=%h expected 1 0 f 00000100",
                         bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o);
    end
    checks++;
    if (bus.ifu_gnt_o !== 1'b0) begin
      errors++; $display("FAIL ifu_early_gnt: got %b expected 0", bus.ifu_gnt_o);
    end
    tick();
    bus.mem_gnt_i = 1'b1;
    #1;
    checks++;
    if ({bus.ifu_gnt_o, bus.lsu_gnt_o} !== 2'b10) begin
      errors++; $display("FAIL ifu_gnt: got %b expected 10", {bus.ifu_gnt_o, bus.lsu_gnt_o});
    end
    tick();
    bus.mem_gnt_i = 1'b0;
    bus.ifu_req_i = 1'b0;
    checks++;
    if ({bus.mem_req_o, state} !== {1'b0, RSP}) begin
      errors++; $display("FAIL ifu_rsp_wait: got req=%b state=%0d expected 0 %0d", bus.mem_req_o, state, RSP);
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_0013;
    #1;
    checks++;
    if ({bus.ifu_rvalid_o, bus.ifu_rdata_o, bus.lsu_rvalid_o, bus.lsu_rdata_o} !== {1'b1, 32'h13, 1'b0, 32'h0}) begin
      errors++; $display("FAIL ifu_rvalid: got ifu %b/%h lsu %b/%h expected 1/00000013 0/00000000",
                         bus.ifu_rvalid_o, bus.ifu_rdata_o, bus.lsu_rvalid_o, bus.lsu_rdata_o);
    end
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    checks++;
    if ({state, bus.ifu_rvalid_o} !== {IDLE, 1'b0}) begin
      errors++; $display("FAIL ifu_back_idle: got state=%0d rvalid=%b expected %0d 0", state, bus.ifu_rvalid_o, IDLE);
    end
  endtask

  task automatic test_lsu_priority();
    logic ok, we; logic [1:0] g, r; logic [31:0] ird, lrd, a, wd; logic [3:0] be;
    bus.ifu_req_i   = 1'b1;
    bus.ifu_addr_i  = 32'h100;
    bus.lsu_req_i   = 1'b1;
    bus.lsu_we_i    = 1'b1;
    bus.lsu_be_i    = 4'h3;
    bus.lsu_addr_i  = 32'h2000;
    bus.lsu_wdata_i = 32'hDEADBEEF;
    run_txn(0, 32'h55, 1'b1, 1'b1, ok, g, r, ird, lrd, we, be, a, wd);
    checks++;
    if ({ok, g, r} !== {1'b1, 2'b01, 2'b01}) begin
      errors++; $display("FAIL prio_lsu_first: got ok=%b gnt=%b rv=%b expected 1 01 01", ok, g, r);
    end
    checks++;
    if ({we, be, a, wd} !== {1'b1, 4'h3, 32'h2000, 32'hDEADBEEF}) begin
      errors++; $display("FAIL prio_lsu_attr: got we=%b be=%h addr=%h wdata=%h expected 1 3 00002000 deadbeef",
                         we, be, a, wd);
    end
    checks++;
    if ({lrd, ird} !== {32'h55, 32'h0}) begin
      errors++; $display("FAIL prio_lsu_rdata: got lsu=%h ifu=%h expected 00000055 00000000", lrd, ird);
    end
    run_txn(0, 32'h77, 1'b1, 1'b1, ok, g, r, ird, lrd, we, be, a, wd);
    checks++;
    if ({ok, g, r, we, be, a, ird} !== {1'b1, 2'b10, 2'b10, 1'b0, 4'hF, 32'h100, 32'h77}) begin
      errors++; $display("FAIL prio_ifu_next: got ok=%b gnt=%b rv=%b we=%b be=%h addr=%h rdata=%h expected 1 10 10 0 f 00000100 00000077",
                         ok, g, r, we, be, a, ird);
    end
  endtask

  task automatic test_starvation();
    logic ok, we; logic [1:0] g, r; logic [31:0] ird, lrd, a, wd; logic [3:0] be;
    logic [1:0] exp_g [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    bus.ifu_req_i   = 1'b1;
    bus.ifu_addr_i  = 32'h104;
    bus.lsu_req_i   = 1'b1;
    bus.lsu_we_i    = 1'b0;
    bus.lsu_be_i    = 4'hF;
    bus.lsu_addr_i  = 32'h3000;
    bus.lsu_wdata_i = '0;
    for (int i = 0; i < 6; i++) begin
      run_txn(0, 32'h1000 + i, 1'b1, 1'b0, ok, g, r, ird, lrd, we, be, a, wd);
      checks++;
      if ({ok, g} !== {1'b1, exp_g[i]}) begin
        errors++; $display("FAIL starve_seq[%0d]: got ok=%b gnt=%b expected 1 %b", i, ok, g, exp_g[i]);
      end
    end
    bus.lsu_req_i = 1'b0;
    tick();
    checks++;
    if ({state, bus.mem_req_o} !== {IDLE, 1'b0}) begin
      errors++; $display("FAIL starve_idle: got state=%0d req=%b expected %0d 0", state, bus.mem_req_o, IDLE);
    end
  endtask

  task automatic test_reset_mid();
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = 1'b0;
    bus.lsu_be_i   = 4'hF;
    bus.lsu_addr_i = 32'h40;
    tick();
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    bus.lsu_req_i = 1'b0;
    checks++;
    if (state !== RSP) begin
      errors++; $display("FAIL rstmid_in_rsp: got %0d expected %0d", state, RSP);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hAA;
    #1;
    checks++;
    if ({state, bus.mem_req_o, bus.lsu_rvalid_o, bus.ifu_rvalid_o, bus.lsu_rdata_o} !== {IDLE, 3'b000, 32'h0}) begin
      errors++; $display("FAIL rstmid_discard: got state=%0d req=%b lrv=%b irv=%b lrd=%h expected %0d 0 0 0 0",
                         state, bus.mem_req_o, bus.lsu_rvalid_o, bus.ifu_rvalid_o, bus.lsu_rdata_o, IDLE);
    end
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    checks++;
    if ({state, bus.mem_req_o} !== {IDLE, 1'b0}) begin
      errors++; $display("FAIL rstmid_after: got state=%0d req=%b expected %0d 0", state, bus.mem_req_o, IDLE);
    end
  endtask

  task automatic test_stray_rvalid();
    int v0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h77;
    #1;
    checks++;
    if ({bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o, bus.lsu_rdata_o} !== '0) begin
      errors++; $display("FAIL stray_idle: got irv=%b lrv=%b ird=%h lrd=%h expected all 0",
                         bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o, bus.lsu_rdata_o);
    end
    tick();
    bus.mem_rvalid_i = 1'b0;
    checks++;
    if (state !== IDLE) begin
      errors++; $display("FAIL stray_idle_state: got %0d expected %0d", state, IDLE);
    end
    bus.lsu_req_i  = 1'b1;
    bus.lsu_addr_i = 32'h80;
    tick();
    bus.mem_rvalid_i = 1'b1;
    #1;
    checks++;
    if ({bus.lsu_rvalid_o, bus.lsu_gnt_o} !== 2'b00) begin
      errors++; $display("FAIL stray_req: got rv=%b gnt=%b expected 0 0", bus.lsu_rvalid_o, bus.lsu_gnt_o);
    end
    v0 = viol_cnt;
    bus.mem_gnt_i = 1'b1;
    #1;
    checks++;
    if ({bus.lsu_gnt_o, bus.lsu_rvalid_o} !== 2'b10) begin
      errors++; $display("FAIL gnt_rv_same: got gnt=%b rv=%b expected 1 0", bus.lsu_gnt_o, bus.lsu_rvalid_o);
    end
    tick();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.lsu_req_i    = 1'b0;
    checks++;
    if ({state, viol_cnt - v0} !== {RSP, 32'd1}) begin
      errors++; $display("FAIL gnt_rv_flag: got state=%0d flagged=%0d expected %0d 1", state, viol_cnt - v0, RSP);
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h99;
    #1;
    checks++;
    if ({bus.lsu_rvalid_o, bus.lsu_rdata_o} !== {1'b1, 32'h99}) begin
      errors++; $display("FAIL gnt_rv_complete: got rv=%b rdata=%h expected 1 00000099", bus.lsu_rvalid_o, bus.lsu_rdata_o);
    end
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic ok, we, early; logic [1:0] g, r; logic [31:0] ird, lrd, a, wd; logic [3:0] be;
    bus.lsu_req_i   = 1'b1;
    bus.lsu_we_i    = 1'b1;
    bus.lsu_be_i    = 4'hF;
    bus.lsu_addr_i  = 32'h500;
    bus.lsu_wdata_i = 32'h1;
    tick();
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    bus.lsu_req_i = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.err_o !== 1'b0 || bus.lsu_rvalid_o !== 1'b0) early = 1'b1;
      tick();
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL tmo_early: got early=%b expected 0", early);
    end
    checks++;
    if ({bus.err_o, bus.lsu_rvalid_o, bus.lsu_rdata_o, bus.ifu_rvalid_o} !== {2'b11, 32'h0, 1'b0}) begin
      errors++; $display("FAIL tmo_pulse: got err=%b lrv=%b lrd=%h irv=%b expected 1 1 0 0",
                         bus.err_o, bus.lsu_rvalid_o, bus.lsu_rdata_o, bus.ifu_rvalid_o);
    end
    tick();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hBAD;
    #1;
    checks++;
    if ({state, bus.err_o, bus.lsu_rvalid_o} !== {IDLE, 2'b00}) begin
      errors++; $display("FAIL tmo_late_rsp: got state=%0d err=%b rv=%b expected %0d 0 0", state, bus.err_o, bus.lsu_rvalid_o, IDLE);
    end
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.lsu_req_i    = 1'b1;
    bus.lsu_we_i     = 1'b0;
    bus.lsu_addr_i   = 32'h600;
    run_txn(0, 32'h1234, 1'b1, 1'b1, ok, g, r, ird, lrd, we, be, a, wd);
    checks++;
    if ({ok, g, r, a, lrd} !== {1'b1, 2'b01, 2'b01, 32'h600, 32'h1234}) begin
      errors++; $display("FAIL tmo_recover: got ok=%b gnt=%b rv=%b addr=%h rdata=%h expected 1 01 01 00000600 00001234",
                         ok, g, r, a, lrd);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    viol_cnt = 0;
    test_reset();
    test_ifu_fetch();
    test_lsu_priority();
    test_starvation();
    test_reset_mid();
    test_stray_rvalid();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++; $display("FAIL final_err: got %b expected 0", bus.err_o);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
